// File: rtl/turbo_ecc_sched.sv
`default_nettype none
// ============================================================================
// Module   : turbo_ecc_sched
// Purpose  : Round-robin scheduler sharing one turbo_ecc encode/decode engine
//            between two requester ports. One job is in flight at a time; the
//            engine result is captured after a fixed latency and returned on a
//            single response channel tagged with the originating port.
// Revision : 1.0 - initial release
// ============================================================================
module turbo_ecc_sched #(
  parameter int DATA_WIDTH     = 8,
  parameter int CODEWORD_WIDTH = 24,
  parameter int ENG_LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // requester side
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic                      req_op0,
  input  logic                      req_op1,
  input  logic [CODEWORD_WIDTH-1:0] req_data0,
  input  logic [CODEWORD_WIDTH-1:0] req_data1,
  // response side
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_port,
  output logic                      rsp_op,
  output logic [CODEWORD_WIDTH-1:0] rsp_data,
  output logic                      rsp_err_det,
  output logic                      rsp_err_cor,
  // engine side
  output logic                      eng_encode_en,
  output logic                      eng_decode_en,
  output logic [DATA_WIDTH-1:0]     eng_data_in,
  output logic [CODEWORD_WIDTH-1:0] eng_codeword_in,
  input  logic [CODEWORD_WIDTH-1:0] eng_codeword_out,
  input  logic [DATA_WIDTH-1:0]     eng_data_out,
  input  logic                      eng_error_detected,
  input  logic                      eng_error_corrected,
  input  logic                      eng_valid_out,
  // status
  output logic                      busy,
  output logic                      eng_fault
);

  // Value loaded into the latency counter when the engine is strobed.
  localparam logic [3:0] c_lat_load = 4'(ENG_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      rr_q, rr_d;        // preferred port on contention
  logic                      port_q, port_d;
  logic                      op_q, op_d;
  logic [CODEWORD_WIDTH-1:0] data_q, data_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      rsp_port_q, rsp_port_d;
  logic                      rsp_op_q, rsp_op_d;
  logic [CODEWORD_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                      rsp_det_q, rsp_det_d;
  logic                      rsp_cor_q, rsp_cor_d;
  logic                      fault_q, fault_d;
  logic [1:0]                gnt;

  // Arbitration: a lone valid port wins; on contention the preferred port wins.
  always_comb begin
    gnt = req_valid;
    if (req_valid == 2'b11) begin
      gnt = rr_q ? 2'b10 : 2'b01;
    end
  end

  // Accept only from IDLE and never while reset is asserted.
  assign req_ready = (state_q == IDLE && rst_n) ? gnt : 2'b00;

  // Next-state, job latch, response capture and engine strobes.
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    port_d        = port_q;
    op_d          = op_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    rsp_port_d    = rsp_port_q;
    rsp_op_d      = rsp_op_q;
    rsp_data_d    = rsp_data_q;
    rsp_det_d     = rsp_det_q;
    rsp_cor_d     = rsp_cor_q;
    fault_d       = fault_q;
    eng_encode_en = 1'b0;
    eng_decode_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_ready) begin
          port_d  = req_ready[1];
          op_d    = req_ready[1] ? req_op1 : req_op0;
          data_d  = req_ready[1] ? req_data1 : req_data0;
          rr_d    = ~req_ready[1];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        eng_encode_en = ~op_q;
        eng_decode_en = op_q;
        cnt_d         = c_lat_load;
        state_d       = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_port_d = port_q;
          rsp_op_d   = op_q;
          if (!op_q) begin
            rsp_data_d = eng_codeword_out;
            rsp_det_d  = 1'b0;
            rsp_cor_d  = 1'b0;
            // An encode result without the engine's valid flag is a protocol
            // fault; the (possibly stale) result is still handed back.
            if (!eng_valid_out) begin
              fault_d = 1'b1;
            end
          end else begin
            rsp_data_d = CODEWORD_WIDTH'(eng_data_out);
            rsp_det_d  = eng_error_detected;
            rsp_cor_d  = eng_error_corrected;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      port_q     <= 1'b0;
      op_q       <= 1'b0;
      data_q     <= '0;
      cnt_q      <= 4'd0;
      rsp_port_q <= 1'b0;
      rsp_op_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_det_q  <= 1'b0;
      rsp_cor_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      port_q     <= port_d;
      op_q       <= op_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      rsp_port_q <= rsp_port_d;
      rsp_op_q   <= rsp_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_det_q  <= rsp_det_d;
      rsp_cor_q  <= rsp_cor_d;
      fault_q    <= fault_d;
    end
  end

  assign rsp_valid       = (state_q == RESP);
  assign rsp_port        = rsp_port_q;
  assign rsp_op          = rsp_op_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_err_det     = rsp_det_q;
  assign rsp_err_cor     = rsp_cor_q;
  assign eng_data_in     = data_q[DATA_WIDTH-1:0];
  assign eng_codeword_in = data_q;
  assign busy            = (state_q != IDLE);
  assign eng_fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_turbo_ecc_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_turbo_ecc_sched
// Purpose  : Self-checking bench for turbo_ecc_sched with a behavioural engine
//            and a job-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_turbo_ecc_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic        req_op0, req_op1;
  logic [23:0] req_data0, req_data1;
  logic        rsp_valid, rsp_ready, rsp_port, rsp_op;
  logic [23:0] rsp_data;
  logic        rsp_err_det, rsp_err_cor;
  logic        eng_encode_en, eng_decode_en;
  logic [7:0]  eng_data_in;
  logic [23:0] eng_codeword_in;
  logic [23:0] e_cw;
  logic [7:0]  e_data;
  logic        e_det, e_cor, e_valid;
  logic        busy, eng_fault;
  logic        force_invalid;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic        exp_pref;   // port expected to win on contention
  int          cur_p;
  logic        cur_op;
  logic [23:0] cur_d;

  always #5 clk = ~clk;

  turbo_ecc_sched dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_op0             (req_op0),
    .req_op1             (req_op1),
    .req_data0           (req_data0),
    .req_data1           (req_data1),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_port            (rsp_port),
    .rsp_op              (rsp_op),
    .rsp_data            (rsp_data),
    .rsp_err_det         (rsp_err_det),
    .rsp_err_cor         (rsp_err_cor),
    .eng_encode_en       (eng_encode_en),
    .eng_decode_en       (eng_decode_en),
    .eng_data_in         (eng_data_in),
    .eng_codeword_in     (eng_codeword_in),
    .eng_codeword_out    (e_cw),
    .eng_data_out        (e_data),
    .eng_error_detected  (e_det),
    .eng_error_corrected (e_cor),
    .eng_valid_out       (e_valid),
    .busy                (busy),
    .eng_fault           (eng_fault)
  );

  // Engine behaviour: codeword = {data, data^DE, data^DE}; decode returns the
  // low byte with error flags derived from the parity of the upper bytes.
  function automatic logic [23:0] ref_rsp_data(input logic op, input logic [23:0] d);
    if (!op) return {d[7:0], d[7:0] ^ 8'hDE, d[7:0] ^ 8'hDE};
    return {16'h0000, d[7:0]};
  endfunction
  function automatic logic ref_det(input logic op, input logic [23:0] d);
    return op & (^d[23:16]);
  endfunction
  function automatic logic ref_cor(input logic op, input logic [23:0] d);
    return op & (^d[23:16]) & (^d[15:8]);
  endfunction

  // Registered one-cycle engine stand-in.
  always @(posedge clk) begin
    if (!rst_n) begin
      e_cw <= 24'h0; e_data <= 8'h0; e_det <= 1'b0; e_cor <= 1'b0; e_valid <= 1'b0;
    end else begin
      e_valid <= 1'b0;
      if (eng_encode_en) begin
        e_cw    <= ref_rsp_data(1'b0, {16'h0, eng_data_in});
        e_det   <= 1'b0;
        e_cor   <= 1'b0;
        e_valid <= !force_invalid;
      end else if (eng_decode_en) begin
        e_data  <= eng_codeword_in[7:0];
        e_det   <= ^eng_codeword_in[23:16];
        e_cor   <= (^eng_codeword_in[23:16]) & (^eng_codeword_in[15:8]);
        e_valid <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a job on port p, wait for the grant, and step into ISSUE.
  task automatic start_job(input int p, input logic op, input logic [23:0] d);
    int n;
    cur_p = p; cur_op = op; cur_d = d;
    if (p == 0) begin req_op0 = op; req_data0 = d; req_valid = 2'b01; end
    else        begin req_op1 = op; req_data1 = d; req_valid = 2'b10; end
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin tick(); n++; end
    chk("grant", {30'd0, req_ready}, (p == 0) ? 32'd1 : 32'd2);
    exp_pref = (p == 0);
    tick();
    req_valid = 2'b00;
    chk("issue_busy", busy, 1);
    chk("issue_strobe", {30'd0, eng_encode_en, eng_decode_en}, op ? 32'd1 : 32'd2);
    chk("issue_cw_in", eng_codeword_in, d);
    chk("issue_data_in", eng_data_in, d[7:0]);
    chk("issue_no_ready", req_ready, 0);
  endtask

  // Wait for the response of the current job and check it against the model.
  task automatic wait_rsp();
    int n;
    n = 1;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk("latency", n, 3);
    chk("rsp_port", rsp_port, cur_p);
    chk("rsp_op", rsp_op, cur_op);
    chk("rsp_data", rsp_data, ref_rsp_data(cur_op, cur_d));
    chk("rsp_det", rsp_err_det, ref_det(cur_op, cur_d));
    chk("rsp_cor", rsp_err_cor, ref_cor(cur_op, cur_d));
  endtask

  task automatic run_job(input int p, input logic op, input logic [23:0] d);
    start_job(p, op, d);
    wait_rsp();
    tick();
    chk("rsp_taken", rsp_valid, 0);
    chk("back_idle", busy, 0);
  endtask

  initial begin
    int          n, got, last_t, n_rsp;
    logic        g, last_g;
    logic [23:0] hold_data;

    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1; force_invalid = 1'b0;
    req_op0 = 1'b0; req_op1 = 1'b1; req_data0 = 24'h0000A5; req_data1 = 24'h123456;
    exp_pref = 1'b0;

    // ---- reset values, requests pending during reset ----
    tick(); tick(); tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_port", rsp_port, 0);
    chk("rst_rsp_op", rsp_op, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_flags", {rsp_err_det, rsp_err_cor}, 0);
    chk("rst_strobes", {eng_encode_en, eng_decode_en}, 0);
    chk("rst_operands", {eng_data_in, eng_codeword_in}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", eng_fault, 0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();

    // ---- directed encode on port 0 and decode on port 1 ----
    run_job(0, 1'b0, 24'h0000A5);
    chk("enc_a5_const", rsp_data, 24'hA57B7B);
    run_job(1, 1'b1, 24'h123456);
    chk("dec_const", rsp_data, 24'h000056);

    // ---- contention: both valid, grants alternate every 4 cycles ----
    req_op0 = 1'b0; req_data0 = 24'($urandom);
    req_op1 = 1'b1; req_data1 = 24'($urandom);
    req_valid = 2'b11;
    #1;
    got = 0; n = 0; last_t = -1; last_g = 1'b0;
    while (got < 4 && n < 60) begin
      if (rsp_valid) begin
        chk("cont_rsp_port", rsp_port, last_g);
        chk("cont_rsp_data", rsp_data,
            last_g ? ref_rsp_data(1'b1, req_data1) : ref_rsp_data(1'b0, req_data0));
      end
      if (req_ready != 2'b00) begin
        g = req_ready[1];
        chk("cont_grant", {30'd0, req_ready}, exp_pref ? 32'd2 : 32'd1);
        if (last_t >= 0) chk("cont_gap", n - last_t, 4);
        exp_pref = ~g; last_t = n; last_g = g; got++;
      end
      if (got < 4) begin tick(); n++; end
    end
    chk("cont_grants", got, 4);
    tick();
    req_valid = 2'b00;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("cont_drain", busy, 0);

    // ---- randomized single-port jobs ----
    for (int i = 0; i < 16; i++) begin
      run_job(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom));
    end

    // ---- backpressure: response held for 10 cycles, other port waiting ----
    rsp_ready = 1'b0;
    start_job(0, 1'b0, 24'($urandom));
    wait_rsp();
    hold_data = ref_rsp_data(1'b0, cur_d);
    req_op1 = 1'b1; req_data1 = 24'($urandom); req_valid = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, hold_data);
      chk("bp_port", rsp_port, 0);
      chk("bp_no_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    n_rsp = 1;
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid && rsp_ready) n_rsp++;
      tick();
    end
    chk("bp_one_rsp", n_rsp, 1);
    chk("bp_idle", busy, 0);

    // ---- engine fault: encode without valid_out ----
    force_invalid = 1'b1;
    start_job(0, 1'b0, 24'($urandom));
    wait_rsp();
    chk("fault_set", eng_fault, 1);
    tick();
    force_invalid = 1'b0;
    run_job(1, 1'b1, 24'($urandom));
    chk("fault_sticky", eng_fault, 1);

    // ---- reset during WAIT drops the job and clears the fault ----
    start_job(1, 1'b1, 24'($urandom));
    tick();
    chk("mid_in_wait", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_fault", eng_fault, 0);
    chk("mid_req_ready", req_ready, 0);
    rst_n = 1'b1;
    exp_pref = 1'b0;
    n_rsp = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid || busy) n_rsp++;
      tick();
    end
    chk("mid_no_rsp", n_rsp, 0);

    // pointer back to port 0 after reset
    req_valid = 2'b11;
    #1;
    chk("rr_after_reset", {30'd0, req_ready}, exp_pref ? 32'd2 : 32'd1);
    req_valid = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/turbo_ecc_sched.md
# turbo_ecc_sched

Round-robin scheduler that shares one `turbo_ecc` encode/decode engine between two requester ports. It accepts encode or decode jobs over valid/ready channels and serialises them onto the engine's `encode_en`/`decode_en` strobes. It captures the engine's registered results after a fixed latency and returns them, tagged with the originating port, on a single valid/ready response channel. It sits between the two host-side clients and the `turbo_ecc` instance.

## Interface
- `DATA_WIDTH`, default 8: engine data width.
- `CODEWORD_WIDTH`, default 24: engine codeword width; also the width of the request and response payload.
- `ENG_LATENCY`, default 1: cycles from an engine enable strobe to valid engine outputs; legal values are 1 to 15.

Ports (clock and reset first):
- `clk`  in  1  single clock; everything is on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  2  per-port request valid; bit p belongs to port p.
- `req_ready`  out  2  per-port accept.
- `req_op0`, `req_op1`  in  1 each  operation: 0 = encode, 1 = decode.
- `req_data0`, `req_data1`  in  CODEWORD_WIDTH each  payload. Encode uses bits [DATA_WIDTH-1:0]; decode uses all bits.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_port`  out  1  originating port.
- `rsp_op`  out  1  echoed operation.
- `rsp_data`  out  CODEWORD_WIDTH  result. Encode returns the codeword; decode returns the data, zero-extended.
- `rsp_err_det`, `rsp_err_cor`  out  1 each  engine error flags; always 0 for encode.
- `eng_encode_en`, `eng_decode_en`  out  1 each  engine strobes.
- `eng_data_in`  out  DATA_WIDTH  engine data operand.
- `eng_codeword_in`  out  CODEWORD_WIDTH  engine codeword operand.
- `eng_codeword_out`  in  CODEWORD_WIDTH  engine encode result.
- `eng_data_out`  in  DATA_WIDTH  engine decode result.
- `eng_error_detected`, `eng_error_corrected`, `eng_valid_out`  in  1 each  engine status.
- `busy`  out  1  high in every state except IDLE.
- `eng_fault`  out  1  sticky protocol-fault flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Exactly one job is outstanding at a time.
- IDLE, arbitration:
  - Only a port with `req_valid` set can be granted.
  - If both ports are valid, grant the port that was not granted last.
  - The round-robin pointer resets to "port 0 preferred".
  - `req_ready[p]` = IDLE && granted(p), computed combinationally; at most one bit is high.
  - On the handshake, latch port, op and data, update the pointer, and go to ISSUE.
- ISSUE (1 cycle):
  - Assert `eng_encode_en` if op is 0, otherwise `eng_decode_en`.
  - Load the latency counter with `ENG_LATENCY`.
  - Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reads 1, capture the response registers from the engine outputs, then go to RESP.
- Capture rules:
  - Encode: `rsp_data` = `eng_codeword_out`; both flags = 0.
  - Encode with `eng_valid_out` = 0 at capture sets `eng_fault`, which is cleared only by reset. The response is still returned.
  - Decode: `rsp_data` = {zeros, `eng_data_out`}; flags copied from the engine.
- RESP:
  - `rsp_valid` = 1 and the response fields are held stable until `rsp_ready`.
  - On the handshake, go to IDLE.
- Engine operand outputs:
  - `eng_data_in` = latched data[DATA_WIDTH-1:0].
  - `eng_codeword_in` = latched data.
  - Both are held stable from ISSUE through the end of WAIT.
  - Enable strobes are 0 in every state except ISSUE.
- Requester rules:
  - A requester holds `req_valid` and its payload until it is accepted.
  - Dropping `req_valid` before acceptance is legal; the request is simply not granted.
  - While not in IDLE, `req_ready` = 00.

## Timing
- Reset values (any cycle with `rst_n` = 0 at the edge):
  - State IDLE; RR pointer = port 0.
  - `req_ready` = 00; `rsp_valid` = 0; `rsp_port`, `rsp_op` and `rsp_data` = 0; both response flags = 0.
  - Engine strobes = 0; engine operand outputs = 0; `busy` = 0; `eng_fault` = 0.
- Reset mid-job (ISSUE, WAIT or RESP): the job is dropped, no response is produced, and the block is in IDLE on the next cycle.
- Latency, with the request handshake in cycle t:
  - ISSUE at t+1.
  - WAIT at t+2 through t+1+ENG_LATENCY.
  - `rsp_valid` first high at t+2+ENG_LATENCY (t+3 at the default).
- Throughput:
  - RESP handshake at cycle r puts the block in IDLE at r+1.
  - The next accept can happen at r+1.
  - Best case is one job every ENG_LATENCY+3 cycles.
- Backpressure: `rsp_ready` held at 0 keeps the block in RESP indefinitely, with no new grants.

## Test plan
- Reset: assert `rst_n` = 0 with both `req_valid` high. All outputs read their reset values, and `req_ready` = 00 during reset.
- Port 0 encode, engine instantiated in the bench:
  - Drive data 0xA5 with `rsp_ready` = 1.
  - Required response: `rsp_data` = 0xA57B7B, `rsp_port` = 0, `rsp_op` = 0, flags 0.
  - `rsp_valid` rises exactly 3 cycles after the handshake.
- Port 1 decode of 0x123456: required response `rsp_data` = 0x000056, flags 0, `rsp_port` = 1.
- Contention: both ports valid continuously, `rsp_ready` = 1. Grants go 0, 1, 0, 1, and each new `req_ready` pulse arrives 4 cycles after the previous one.
- Backpressure: hold `rsp_ready` = 0 for 10 cycles during RESP. `rsp_*` stays stable, `req_ready` = 00, and exactly one response is delivered when `rsp_ready` rises.
- Fault and mid-job reset:
  - Tie `eng_valid_out` to 0 during an encode: `eng_fault` becomes 1 and stays set.
  - Pulse `rst_n` low during WAIT: no response appears, `eng_fault` = 0, and the block is in IDLE.
